// File: rtl/croc_sram_bank_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM bank (1-cycle read latency) between NumMgr OBI managers.
// Define CROC_SRAM_ARB_STATS_EN to build the contention counter behind stall_cnt_o.
module croc_sram_bank_arbiter #(
  parameter int unsigned NumMgr        = 3,
  parameter int unsigned IdWidth       = 1,
  parameter logic [31:0] SramBaseAddr  = 32'h1000_0000,
  parameter int unsigned SramNumWords  = 1024,
  parameter int unsigned SramAddrWidth = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumMgr-1:0]           req_i,
  input  logic [NumMgr*32-1:0]        addr_i,
  input  logic [NumMgr-1:0]           we_i,
  input  logic [NumMgr*4-1:0]         be_i,
  input  logic [NumMgr*32-1:0]        wdata_i,
  input  logic [NumMgr*IdWidth-1:0]   aid_i,
  output logic [NumMgr-1:0]           gnt_o,
  output logic [NumMgr-1:0]           rvalid_o,
  output logic [NumMgr*32-1:0]        rdata_o,
  output logic [NumMgr*IdWidth-1:0]   rid_o,
  output logic [NumMgr-1:0]           err_o,
  output logic                        sram_req_o,
  output logic                        sram_we_o,
  output logic [SramAddrWidth-1:0]    sram_addr_o,
  output logic [3:0]                  sram_be_o,
  output logic [31:0]                 sram_wdata_o,
  input  logic [31:0]                 sram_rdata_i,
  output logic [15:0]                 stall_cnt_o,
  input  logic                        stall_clr_i
);

  localparam int unsigned PtrWidth = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  // 33-bit end address so a bank ending at 4 GiB does not wrap the compare.
  localparam logic [32:0] SramEndAddr = {1'b0, SramBaseAddr} + (33'(SramNumWords) << 2);

  function automatic logic [PtrWidth-1:0] rot_idx(input logic [PtrWidth-1:0] base,
                                                  input int unsigned ofs);
    int unsigned sum;
    sum = 32'(base) + ofs;
    if (sum >= NumMgr) sum = sum - NumMgr;
    return PtrWidth'(sum);
  endfunction

  logic [PtrWidth-1:0] rr_ptr;
  logic [PtrWidth-1:0] winner;
  logic                any_req;
  logic                grant;

  logic [31:0]         sel_addr;
  logic                sel_we;
  logic [3:0]          sel_be;
  logic [31:0]         sel_wdata;
  logic [IdWidth-1:0]  sel_aid;
  logic                in_range;

  logic                resp_valid;
  logic [PtrWidth-1:0] resp_mgr;
  logic [IdWidth-1:0]  resp_id;
  logic                resp_err;
  logic                resp_we;

  // First requester at or above rr_ptr, wrapping modulo NumMgr.
  always_comb begin
    any_req = 1'b0;
    winner  = rr_ptr;
    for (int unsigned k = 0; k < NumMgr; k++) begin
      if (!any_req && req_i[rot_idx(rr_ptr, k)]) begin
        any_req = 1'b1;
        winner  = rot_idx(rr_ptr, k);
      end
    end
  end

  assign grant = any_req && !rst_i;

  always_comb begin
    gnt_o = '0;
    if (grant) gnt_o[winner] = 1'b1;
  end

  assign sel_addr  = addr_i[winner*32 +: 32];
  assign sel_we    = we_i[winner];
  assign sel_be    = be_i[winner*4 +: 4];
  assign sel_wdata = wdata_i[winner*32 +: 32];
  assign sel_aid   = aid_i[winner*IdWidth +: IdWidth];

  assign in_range = ({1'b0, sel_addr} >= {1'b0, SramBaseAddr}) &&
                    ({1'b0, sel_addr} <  SramEndAddr);

  assign sram_req_o   = grant && in_range;
  assign sram_we_o    = sel_we;
  assign sram_addr_o  = sel_addr[SramAddrWidth+1:2];
  assign sram_be_o    = sel_be;
  assign sram_wdata_o = sel_wdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= rot_idx(winner, 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_valid <= 1'b0;
      resp_mgr   <= '0;
      resp_id    <= '0;
      resp_err   <= 1'b0;
      resp_we    <= 1'b0;
    end else begin
      resp_valid <= grant;
      if (grant) begin
        resp_mgr <= winner;
        resp_id  <= sel_aid;
        resp_err <= !in_range;
        resp_we  <= sel_we;
      end
    end
  end

  // Response is gated by reset so a pending beat is dropped in the reset cycle itself.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    rid_o    = '0;
    err_o    = '0;
    if (resp_valid && !rst_i) begin
      rvalid_o[resp_mgr]                   = 1'b1;
      rid_o[resp_mgr*IdWidth +: IdWidth]   = resp_id;
      err_o[resp_mgr]                      = resp_err;
      rdata_o[resp_mgr*32 +: 32]           = (resp_err || resp_we) ? 32'h0 : sram_rdata_i;
    end
  end

`ifdef CROC_SRAM_ARB_STATS_EN
  logic [15:0] stall_cnt;
  logic        contention;

  assign contention = $countones(req_i) >= 2;

  always_ff @(posedge clk_i) begin
    if (rst_i || stall_clr_i) begin
      stall_cnt <= '0;
    end else if (contention && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  logic unused_stall_clr;
  assign unused_stall_clr = stall_clr_i;
  assign stall_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_croc_sram_bank_arbiter.sv
// Randomized bench for croc_sram_bank_arbiter against a behavioural round-robin / bank model.
module tb_croc_sram_bank_arbiter;

  localparam int N = 3;
  localparam int IW = 1;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int WORDS = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [N-1:0]     req, we;
  logic [N*32-1:0]  addr, wdata;
  logic [N*4-1:0]   be;
  logic [N*IW-1:0]  aid;
  logic             stall_clr;
  logic [N-1:0]     gnt, rvalid, err;
  logic [N*32-1:0]  rdata;
  logic [N*IW-1:0]  rid;
  logic             sram_req, sram_we;
  logic [9:0]       sram_addr;
  logic [3:0]       sram_be;
  logic [31:0]      sram_wdata, sram_rdata;
  logic [15:0]      stall_cnt;

  croc_sram_bank_arbiter #(
    .NumMgr(N), .IdWidth(IW), .SramBaseAddr(BASE), .SramNumWords(WORDS), .SramAddrWidth(10)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .aid_i(aid), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .rid_o(rid), .err_o(err), .sram_req_o(sram_req), .sram_we_o(sram_we),
    .sram_addr_o(sram_addr), .sram_be_o(sram_be), .sram_wdata_o(sram_wdata),
    .sram_rdata_i(sram_rdata), .stall_cnt_o(stall_cnt), .stall_clr_i(stall_clr)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    if (i == 2) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_9E37);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // SRAM macro: 1-cycle read latency, junk on the read port when not reading.
  logic [31:0] sram_mem [WORDS];
  bit mem_ready = 0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < WORDS; i++) sram_mem[i] <= init_val(i);
      mem_ready <= 1;
      sram_rdata <= $urandom;
    end else if (sram_req) begin
      if (sram_we) sram_mem[sram_addr] <= merge(sram_mem[sram_addr], sram_wdata, sram_be);
      sram_rdata <= sram_we ? $urandom : sram_mem[sram_addr];
    end else begin
      sram_rdata <= $urandom;
    end
  end

  // Reference model state
  logic [31:0]   ref_mem [WORDS];
  int            ref_ptr;
  bit            pend_v;
  int            pend_mgr;
  logic [IW-1:0] pend_id;
  bit            pend_err;
  logic [31:0]   pend_data;
  logic [15:0]   ref_stall;

  task automatic tick();
    bit g, inr;
    int w, word;
    logic [31:0] a;
    logic [N-1:0] e_gnt, e_rv, e_err;
    logic [N*32-1:0] e_rd;
    logic [N*IW-1:0] e_rid;
    @(negedge clk);
    g = 0; w = 0;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        if (!g && req[(ref_ptr + k) % N]) begin
          g = 1;
          w = (ref_ptr + k) % N;
        end
      end
    end
    e_gnt = '0;
    if (g) e_gnt[w] = 1'b1;
    check_val("gnt", gnt, e_gnt);
    a = addr[w*32 +: 32];
    inr = g && (a >= BASE) && ((a - BASE) < 32'(WORDS * 4));
    word = inr ? int'((a - BASE) >> 2) : 0;
    check_val("sram_req", sram_req, inr);
    if (inr) begin
      check_val("sram_addr", sram_addr, word);
      check_val("sram_we", sram_we, we[w]);
      check_val("sram_be", sram_be, be[w*4 +: 4]);
      check_val("sram_wdata", sram_wdata, wdata[w*32 +: 32]);
    end
    e_rv = '0; e_err = '0; e_rd = '0; e_rid = '0;
    if (pend_v && !rst) begin
      e_rv[pend_mgr] = 1'b1;
      e_err[pend_mgr] = pend_err;
      e_rid[pend_mgr*IW +: IW] = pend_id;
      e_rd[pend_mgr*32 +: 32] = pend_data;
    end
    check_val("rvalid", rvalid, e_rv);
    check_val("err", err, e_err);
    check_val("rid", rid, e_rid);
    check_val("rdata", rdata, e_rd);
    check_val("stall_cnt", stall_cnt, ref_stall);
    @(posedge clk);
    if (rst) begin
      ref_ptr = 0;
      pend_v = 0;
    end else begin
      pend_v = g;
      if (g) begin
        pend_mgr = w;
        pend_id = aid[w*IW +: IW];
        pend_err = !inr;
        pend_data = (!inr || we[w]) ? 32'h0 : ref_mem[word];
        if (inr && we[w]) ref_mem[word] = merge(ref_mem[word], wdata[w*32 +: 32], be[w*4 +: 4]);
        ref_ptr = (w + 1) % N;
      end
    end
`ifdef CROC_SRAM_ARB_STATS_EN
    if (rst || stall_clr) ref_stall = 0;
    else if ($countones(req) >= 2 && ref_stall != 16'hFFFF) ref_stall = ref_stall + 16'd1;
`else
    ref_stall = 0;
`endif
    #1;
  endtask

  task automatic set_mgr(input int m, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] d, input logic [IW-1:0] id);
    addr[m*32 +: 32] = a;
    we[m] = w;
    be[m*4 +: 4] = b;
    wdata[m*32 +: 32] = d;
    aid[m*IW +: IW] = id;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 11);
    case (r)
      0: return 32'h0FFF_FFFC;
      1: return 32'h1000_1000;
      2: return 32'hFFFF_FFFC;
      3: return 32'h0000_0000;
      4, 5, 6: return BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      default: return BASE + 32'($urandom_range(0, WORDS - 1) * 4) + 32'($urandom_range(0, 3));
    endcase
  endfunction

  logic [31:0] tmp;

  initial begin
    rst = 1; stall_clr = 0;
    req = '0; we = '0; addr = '0; wdata = '0; be = '0; aid = '0;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_val(i);
    ref_ptr = 0; pend_v = 0; pend_mgr = 0; pend_id = '0; pend_err = 0; pend_data = '0;
    ref_stall = 0;
    for (int m = 0; m < N; m++) set_mgr(m, BASE + 32'(m * 4), 1'b0, 4'hF, 32'h0, '0);

    // Reset with everyone requesting: no grant, no response
    req = 3'b111;
    tick();
    tick();

    // Contention from reset: grants 0,1,2,0,1,2
    rst = 0;
    #1;
    for (int i = 0; i < 6; i++) begin
      check_val("rr_seq", gnt, 3'b001 << (i % 3));
      tick();
    end
`ifdef CROC_SRAM_ARB_STATS_EN
    check_val("stall_after6", stall_cnt, 16'd6);
`else
    check_val("stall_after6", stall_cnt, 16'd0);
`endif

    // Single read by mgr1
    req = 3'b010;
    set_mgr(1, 32'h1000_0008, 1'b0, 4'hF, 32'h0, 1'b1);
    #1;
    check_val("rd_gnt", gnt, 3'b010);
    check_val("rd_sram_addr", sram_addr, 10'd2);
    tick();
    req = 3'b000;
    #1;
    check_val("rd_rvalid", rvalid, 3'b010);
    check_val("rd_rdata", rdata[63:32], 32'hDEAD_BEEF);
    check_val("rd_rid", rid, 3'b010);
    tick();

    // Write then read back top word
    req = 3'b001;
    set_mgr(0, 32'h1000_0FFC, 1'b1, 4'b0011, 32'hA5A5_5A5A, 1'b0);
    #1;
    check_val("wr_sram_addr", sram_addr, 10'd1023);
    check_val("wr_sram_be", sram_be, 4'b0011);
    tick();
    set_mgr(0, 32'h1000_0FFC, 1'b0, 4'hF, 32'h0, 1'b1);
    tick();
    req = 3'b000;
    #1;
    tmp = init_val(1023);
    check_val("wr_readback", rdata[31:0], {tmp[31:16], 16'h5A5A});
    tick();

    // Out-of-range reads by mgr2, back to back
    req = 3'b100;
    set_mgr(2, 32'h1000_1000, 1'b0, 4'hF, 32'h0, 1'b0);
    tick();
    set_mgr(2, 32'h0FFF_FFFC, 1'b0, 4'hF, 32'h0, 1'b1);
    tick();
    req = 3'b000;
    #1;
    check_val("oor_err", err, 3'b100);
    tick();

    // Reset mid-operation
    req = 3'b010;
    set_mgr(1, 32'h1000_0010, 1'b0, 4'hF, 32'h0, 1'b0);
    tick();
    rst = 1;
    req = 3'b011;
    #1;
    check_val("rst_rvalid", rvalid, 3'b000);
    tick();
    rst = 0;
    req = 3'b110;
    #1;
    check_val("rst_first_gnt", gnt, 3'b010);
    tick();
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      req = N'($urandom);
      for (int m = 0; m < N; m++)
        set_mgr(m, rand_addr(), 1'($urandom), 4'($urandom), $urandom, IW'($urandom));
      stall_clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0;
    stall_clr = 0;

`ifdef CROC_SRAM_ARB_STATS_EN
    // Saturation, then clear alongside contention
    req = 3'b111;
    for (int c = 0; c < 70000; c++) tick();
    check_val("stall_sat", stall_cnt, 16'hFFFF);
    stall_clr = 1;
    tick();
    stall_clr = 0;
    #1;
    check_val("stall_clr", stall_cnt, 16'h0000);
    tick();
`endif

    req = '0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
